// File: rtl/updown_pkg.sv
// Shared encodings for the up/down run controller: FSM states and mode-digit patterns.
package updown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN_UP = 2'd1,
        ST_RUN_DN = 2'd2,
        ST_PAUSE  = 2'd3
    } state_t;

    // Segment patterns, bit6..bit0, active-high.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_U     = 7'b0111110;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    function automatic logic [6:0] seg_for_state(state_t s);
        logic [6:0] seg;
        case (s)
            ST_RUN_UP: seg = SEG_U;
            ST_RUN_DN: seg = SEG_D;
            ST_PAUSE:  seg = SEG_DASH;
            default:   seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic is_run(state_t s);
        return (s == ST_RUN_UP) || (s == ST_RUN_DN);
    endfunction

endpackage

// File: rtl/updown_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle press
// pulse on each qualified rising edge of the debounced level.
module btn_debounce
    import updown_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [1:0]    fill_q, fill_d;
    logic          armed_q, armed_d;
    logic          level_q, level_d;
    logic          level_dly_q, level_dly_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state logic for synchroniser, stability counter and press detector.
    // fill_q marks when sync2_q holds a real sample rather than its reset value;
    // armed_q stays low until a genuine released sample is seen, so a button held
    // through reset cannot produce a press when its level re-qualifies.
    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        fill_d      = {fill_q[0], 1'b1};
        armed_d     = armed_q | (fill_q[1] & ~sync2_q);
        level_d     = level_q;
        level_dly_d = level_q;
        cnt_d       = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = armed_q & level_q & ~level_dly_q;
    end

    // State registers, synchronous reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/updown_ctrl.sv
// Run/direction controller for the 4-bit up/down counter: debounces the three
// buttons, runs the run/pause/direction FSM, paces counting with a tick divider
// and drives the mode digit.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   ST_IDLE   | cleared, not counting, digit blank
//   ST_RUN_UP | counting up on every divider tick, digit "U"
//   ST_RUN_DN | counting down on every divider tick, digit "d"
//   ST_PAUSE  | holding value, dir still toggleable, digit "-"
module updown_ctrl
    import updown_pkg::*;
#(
    parameter int DIV       = 50_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int WRAP      = 1
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_dir,
    input  logic       btn_clr,
    input  logic [3:0] cnt_val,
    output logic       cnt_en,
    output logic       cnt_up,
    output logic       cnt_clr,
    output logic [1:0] state,
    output logic [6:0] segment,
    output logic       digit
);

    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic press_run, press_dir, press_clr;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .CLK     (CLK),
        .rst     (rst),
        .btn_raw (btn_run),
        .press   (press_run)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
        .CLK     (CLK),
        .rst     (rst),
        .btn_raw (btn_dir),
        .press   (press_dir)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .CLK     (CLK),
        .rst     (rst),
        .btn_raw (btn_clr),
        .press   (press_clr)
    );

    state_t        state_q, state_d;
    logic          dir_q, dir_d;
    logic [DW-1:0] div_q, div_d;
    logic          cnt_en_q, cnt_en_d;
    logic          cnt_clr_q, cnt_clr_d;
    logic [6:0]    seg_q, seg_d;
    logic          digit_q, digit_d;
    logic          at_limit;

    assign at_limit = ((state_q == ST_RUN_UP) && (cnt_val == 4'hF)) ||
                      ((state_q == ST_RUN_DN) && (cnt_val == 4'h0));

    // Next state, divider and strobes. Presses take precedence over a tick in
    // the same cycle; every press that is acted on restarts the divider so the
    // first tick of a new run segment lands a full DIV cycles later.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        div_d     = div_q;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;
        if (press_clr) begin
            cnt_clr_d = 1'b1;
            state_d   = ST_IDLE;
            div_d     = '0;
        end else if (press_run) begin
            div_d = '0;
            case (state_q)
                ST_IDLE, ST_PAUSE: state_d = dir_q ? ST_RUN_UP : ST_RUN_DN;
                default:           state_d = ST_PAUSE;
            endcase
        end else if (press_dir) begin
            dir_d = ~dir_q;
            div_d = '0;
            case (state_q)
                ST_RUN_UP: state_d = ST_RUN_DN;
                ST_RUN_DN: state_d = ST_RUN_UP;
                default:   state_d = state_q;
            endcase
        end else if (is_run(state_q)) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if ((WRAP == 0) && at_limit) begin
                    state_d = ST_PAUSE;
                end else begin
                    cnt_en_d = 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end else begin
            div_d = '0;
        end
        seg_d   = seg_for_state(state_d);
        digit_d = |seg_d;
    end

    // Controller registers, synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b1;
            div_q     <= '0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            seg_q     <= SEG_BLANK;
            digit_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            div_q     <= div_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            seg_q     <= seg_d;
            digit_q   <= digit_d;
        end
    end

    assign state   = state_q;
    assign cnt_up  = dir_q;
    assign cnt_en  = cnt_en_q;
    assign cnt_clr = cnt_clr_q;
    assign segment = seg_q;
    assign digit   = digit_q;

endmodule

// File: tb/tb_updown_ctrl.sv
// Scoreboard bench for updown_ctrl. Two instances share the clock and reset:
// dut0 with WRAP=1, dut1 with WRAP=0. Stimulus pushes hand-timed expected
// events (state change, direction change, cnt_en or cnt_clr) into a queue; a
// monitor pops and compares each event the DUTs present.
module tb_updown_ctrl;

    localparam int DIV = 4;
    localparam int DB  = 3;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst;
    logic       run0, dir0, clr0, run1, dir1, clr1;
    logic [3:0] val0, val1;
    logic       en0, up0, clro0, dig0, en1, up1, clro1, dig1;
    logic [1:0] st0, st1;
    logic [6:0] seg0, seg1;

    updown_ctrl #(.DIV(DIV), .DB_CYCLES(DB), .WRAP(1)) u_dut0 (
        .CLK(CLK), .rst(rst), .btn_run(run0), .btn_dir(dir0), .btn_clr(clr0),
        .cnt_val(val0), .cnt_en(en0), .cnt_up(up0), .cnt_clr(clro0),
        .state(st0), .segment(seg0), .digit(dig0)
    );

    updown_ctrl #(.DIV(DIV), .DB_CYCLES(DB), .WRAP(0)) u_dut1 (
        .CLK(CLK), .rst(rst), .btn_run(run1), .btn_dir(dir1), .btn_clr(clr1),
        .cnt_val(val1), .cnt_en(en1), .cnt_up(up1), .cnt_clr(clro1),
        .state(st1), .segment(seg1), .digit(dig1)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         at;
        int         dut;
        logic [1:0] st;
        logic       en;
        logic       clr;
        logic       up;
    } ev_t;

    ev_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [1:0] prev_st [2];
    logic       prev_up [2];

    function automatic logic [6:0] seg_exp(logic [1:0] s);
        case (s)
            2'd1:    return 7'b0111110;
            2'd2:    return 7'b1011110;
            2'd3:    return 7'b1000000;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic expect_ev(int at, int d, logic [1:0] s, logic e, logic c, logic u);
        ev_t ev;
        ev.at = at; ev.dut = d; ev.st = s; ev.en = e; ev.clr = c; ev.up = u;
        sb.push_back(ev);
    endtask

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic observe(int d, logic [1:0] st, logic en, logic clr, logic up,
                           logic [6:0] seg, logic dig);
        ev_t e;
        if (rst) begin
            prev_st[d] = st;
            prev_up[d] = up;
            return;
        end
        if (en || clr || (st != prev_st[d]) || (up != prev_up[d])) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: dut%0d cyc=%0d state=%0d en=%0b clr=%0b up=%0b seg=%b",
                         d, cyc, st, en, clr, up, seg);
            end else begin
                e = sb.pop_front();
                if (e.dut != d || e.at != cyc || e.st != st || e.en != en || e.clr != clr ||
                    e.up != up || seg != seg_exp(e.st) || dig != (|seg_exp(e.st))) begin
                    errors++;
                    $display("FAIL event: got dut%0d cyc=%0d st=%0d en=%0b clr=%0b up=%0b seg=%b dig=%0b; expected dut%0d cyc=%0d st=%0d en=%0b clr=%0b up=%0b seg=%b dig=%0b",
                             d, cyc, st, en, clr, up, seg, dig,
                             e.dut, e.at, e.st, e.en, e.clr, e.up, seg_exp(e.st), |seg_exp(e.st));
                end
            end
        end
        prev_st[d] = st;
        prev_up[d] = up;
    endtask

    always @(negedge CLK) begin
        observe(0, st0, en0, clro0, up0, seg0, dig0);
        observe(1, st1, en1, clro1, up1, seg1, dig1);
    end

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge CLK);
    endtask

    // Raw buttons {clr,dir,run} high for the edges c..c+3.
    task automatic press(int d, logic [2:0] m, int c);
        wait_cyc(c - 1);
        if (cyc != c - 1) begin
            errors++;
            $display("FAIL schedule: at cyc %0d wanted %0d", cyc, c - 1);
        end
        if (d == 0) {clr0, dir0, run0} = m; else {clr1, dir1, run1} = m;
        repeat (4) @(negedge CLK);
        if (d == 0) {clr0, dir0, run0} = 3'b000; else {clr1, dir1, run1} = 3'b000;
    endtask

    task automatic chk_reset_state(int d);
        if (d == 0) begin
            chk("rst_state0", st0, 0);   chk("rst_up0", up0, 1);
            chk("rst_en0", en0, 0);      chk("rst_clr0", clro0, 0);
            chk("rst_seg0", seg0, 0);    chk("rst_digit0", dig0, 0);
        end else begin
            chk("rst_state1", st1, 0);   chk("rst_up1", up1, 1);
            chk("rst_en1", en1, 0);      chk("rst_clr1", clro1, 0);
            chk("rst_seg1", seg1, 0);    chk("rst_digit1", dig1, 0);
        end
    endtask

    localparam int T = 40;
    localparam int U = 140;
    localparam int V = 200;
    localparam int W = 240;

    initial begin
        rst = 1'b1;
        {run0, dir0, clr0, run1, dir1, clr1} = '0;
        val0 = 4'hF;
        val1 = 4'hF;
        repeat (4) @(negedge CLK);
        chk_reset_state(0);
        chk_reset_state(1);
        rst = 1'b0;

        // 2-cycle glitch on btn_run in IDLE: no event may appear
        wait_cyc(19);
        run0 = 1'b1;
        repeat (2) @(negedge CLK);
        run0 = 1'b0;

        // dut0 (WRAP=1, cnt_val=F so the wrap case issues cnt_en at the top)
        expect_ev(T+6,  0, 2'd1, 0, 0, 1);
        expect_ev(T+10, 0, 2'd1, 1, 0, 1);
        expect_ev(T+14, 0, 2'd1, 1, 0, 1);
        expect_ev(T+18, 0, 2'd1, 1, 0, 1);
        expect_ev(T+22, 0, 2'd1, 1, 0, 1);
        expect_ev(T+26, 0, 2'd2, 0, 0, 0);   // dir press coincides with tick: no cnt_en
        expect_ev(T+30, 0, 2'd2, 1, 0, 0);
        expect_ev(T+34, 0, 2'd2, 1, 0, 0);
        expect_ev(T+36, 0, 2'd3, 0, 0, 0);
        expect_ev(T+50, 0, 2'd2, 0, 0, 0);
        expect_ev(T+54, 0, 2'd2, 1, 0, 0);
        expect_ev(T+58, 0, 2'd2, 1, 0, 0);
        expect_ev(T+62, 0, 2'd2, 1, 0, 0);
        expect_ev(T+66, 0, 2'd1, 0, 0, 1);
        expect_ev(T+70, 0, 2'd1, 1, 0, 1);
        expect_ev(T+74, 0, 2'd1, 1, 0, 1);
        expect_ev(T+78, 0, 2'd0, 0, 1, 1);   // clr wins over run and dir
        press(0, 3'b001, T);
        press(0, 3'b010, T+20);
        press(0, 3'b001, T+30);
        press(0, 3'b001, T+44);
        press(0, 3'b010, T+60);
        press(0, 3'b111, T+72);

        // dut1 (WRAP=0): stops at the limits instead of wrapping
        expect_ev(U+6,  1, 2'd1, 0, 0, 1);
        expect_ev(U+10, 1, 2'd3, 0, 0, 1);   // RUN_UP at F on a tick
        expect_ev(U+20, 1, 2'd3, 0, 0, 0);   // dir toggles inside PAUSE
        expect_ev(U+30, 1, 2'd2, 0, 0, 0);
        expect_ev(U+34, 1, 2'd2, 1, 0, 0);
        expect_ev(U+38, 1, 2'd2, 1, 0, 0);
        expect_ev(U+42, 1, 2'd3, 0, 0, 0);   // RUN_DN at 0 on a tick
        press(1, 3'b001, U);
        press(1, 3'b010, U+14);
        press(1, 3'b001, U+24);
        wait_cyc(U+38);
        val1 = 4'h0;

        // reset mid-operation with btn_run held through it
        wait_cyc(V-1);
        run0 = 1'b1;
        rst  = 1'b1;
        repeat (3) @(negedge CLK);
        chk_reset_state(0);
        chk_reset_state(1);
        rst = 1'b0;
        wait_cyc(V+20);
        run0 = 1'b0;

        expect_ev(W+6,  0, 2'd1, 0, 0, 1);
        expect_ev(W+10, 0, 2'd1, 1, 0, 1);
        expect_ev(W+14, 0, 2'd1, 1, 0, 1);
        press(0, 3'b001, W);
        wait_cyc(W+16);

        chk("events_outstanding", sb.size(), 0);
        while (sb.size() > 0) begin
            ev_t e;
            e = sb.pop_front();
            $display("FAIL missing_event: dut%0d cyc=%0d st=%0d en=%0b clr=%0b up=%0b",
                     e.dut, e.at, e.st, e.en, e.clr, e.up);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
